// File: rtl/fir_pkg.sv
// Shared definitions for the 3-tap FIR and its decimating averager.
// round_avg is the single definition of the rounding average, kept here so other users compute it the same way.
package fir_pkg;

    localparam int FIR_DATA_W     = 16;
    localparam int DEF_LOG2_DECIM = 2;
    localparam int AVG_W          = 32;

    // Round-half-up divide by 2^log2_decim; log2_decim = 0 passes the sum through.
    function automatic logic [AVG_W-1:0] round_avg(input logic [AVG_W-1:0] sum,
                                                   input int              log2_decim);
        logic [AVG_W-1:0] half;
        if (log2_decim == 0) begin
            return sum;
        end
        half = AVG_W'(1) << (log2_decim - 1);
        return (sum + half) >> log2_decim;
    endfunction

endpackage

// File: rtl/fir_decim_avg_if.sv
// Sample input and averaged-result handshake between the FIR, the averager and its consumer.
interface fir_decim_avg_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              overflow;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  overflow
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output out_data,
        output out_valid,
        output overflow
    );
endinterface

// File: rtl/fir_out_fifo.sv
// Registered synchronous FIFO for averaged results; no path from push_data to pop_data.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module fir_out_fifo #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              empty
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;
    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic              do_push;
    logic              do_pop;

    always_comb begin
        full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        empty    = (wptr_q == rptr_q);
        pop_data = mem_q[rptr_q[AW-1:0]];
        do_pop   = pop && !empty;
        // At full, the slot being written is the one being popped this edge.
        do_push  = push && (!full || do_pop);
        wptr_d   = do_push ? wptr_q + (AW+1)'(1) : wptr_q;
        rptr_d   = do_pop  ? rptr_q + (AW+1)'(1) : rptr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wptr_q[AW-1:0]] <= push_data;
            end
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule

// File: rtl/fir_decim_avg.sv
// Averages non-overlapping groups of 2^LOG2_DECIM FIR samples (round-half-up) into an output FIFO.
// The input is never stalled; results arriving at a full FIFO are dropped and flagged in a sticky overflow.
module fir_decim_avg
    import fir_pkg::*;
#(
    parameter int DATA_W     = FIR_DATA_W,
    parameter int LOG2_DECIM = DEF_LOG2_DECIM,
    parameter int FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             rst,
    fir_decim_avg_if.slave  bus
);
    localparam int DECIM = 1 << LOG2_DECIM;
    localparam int SUM_W = DATA_W + LOG2_DECIM;
    localparam int PH_W  = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;

    logic [SUM_W-1:0]  acc_q, acc_d;
    logic [SUM_W-1:0]  sum;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic              ovf_q, ovf_d;
    logic              is_final;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] pop_data;

    always_comb begin
        sum      = acc_q + SUM_W'(bus.in_data);
        is_final = (LOG2_DECIM == 0) || (ph_q == PH_W'(DECIM - 1));
        // Rounding headroom comes from the 32-bit helper; the shifted value always fits DATA_W.
        result   = DATA_W'(round_avg(AVG_W'(sum), LOG2_DECIM));
        push     = bus.in_valid && is_final;
        pop      = !empty && bus.out_ready;
        acc_d    = acc_q;
        ph_d     = ph_q;
        if (bus.in_valid) begin
            if (is_final) begin
                acc_d = '0;
                ph_d  = '0;
            end else begin
                acc_d = sum;
                ph_d  = ph_q + PH_W'(1);
            end
        end
        ovf_d = ovf_q | (push && full && !pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            ph_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ph_q  <= ph_d;
            ovf_q <= ovf_d;
        end
    end

    fir_out_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (result),
        .full      (full),
        .pop       (pop),
        .pop_data  (pop_data),
        .empty     (empty)
    );

    assign bus.out_data  = pop_data;
    assign bus.out_valid = !empty;
    assign bus.overflow  = ovf_q;

endmodule
